ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Multi-cycle control sequencer for the 16-bit RISC core. Steps each instruction through fetch, decode, register read, ALU, optional memory access and write-back by asserting one stage enable per cycle. Drives the instruction decoder's enable, handshakes with the memory interface, and detects HALT and memory-timeout faults. Sits between the top level and the fetch unit, decoder, register file, ALU and memory port.

## Interface
- MAX_WAIT, 8, max consecutive not-ready cycles tolerated in FETCH/MEM (≥1)
- CNT_W, 16, width of retired-instruction counter

- I_clk  in  1  clock, all state on rising edge
- I_rst_n  in  1  asynchronous, active-low reset
- I_run  in  1  level; 1 = keep issuing instructions
- I_mem_ready  in  1  memory completes current request this cycle
- I_opcode  in  5  opcode from instruction decoder
- I_regwe  in  1  write-enable flag from instruction decoder
- O_state  out  4  current state code
- O_en_fetch  out  1  fetch stage enable
- O_en_decode  out  1  decoder enable
- O_pc_inc  out  1  PC increment strobe
- O_en_regread  out  1  register-file read enable
- O_en_alu  out  1  ALU enable
- O_mem_req  out  1  memory request
- O_mem_we  out  1  memory write (store)
- O_en_regwrite  out  1  register-file write enable
- O_halted  out  1  HALT executed
- O_fault  out  1  memory timeout
- O_retired  out  CNT_W  instructions completed

## Operation
- States (O_state): IDLE=0, FETCH=1, DECODE=2, REGREAD=3, ALU=4, MEM=5, WB=6, HALT=7, FAULT=8.
- All control outputs Moore-decoded from state register only.
- Opcode classes: LOAD = I_opcode[4:1]==4'b1000; STORE = 4'b1001; HALT = 5'b11111; others use I_regwe.
- IDLE: no outputs. I_run=1 → FETCH.
- FETCH: O_en_fetch=1, O_mem_req=1. I_mem_ready=1 → DECODE.
- DECODE: O_en_decode=1, O_pc_inc=1 (exactly one cycle). Opcode HALT → HALT; else REGREAD.
- REGREAD: O_en_regread=1 → ALU.
- ALU: O_en_alu=1. LOAD/STORE → MEM; else I_regwe=1 → WB; else instruction complete.
- MEM: O_mem_req=1, O_mem_we=1 for STORE. I_mem_ready=1: LOAD → WB; STORE → complete.
- WB: O_en_regwrite=1 → complete.
- "Complete": O_retired += 1 (wraps modulo 2^CNT_W); next state FETCH if I_run=1, else IDLE.
- HALT: O_halted=1; sticky until reset; I_run ignored; not counted in O_retired.
- FAULT: O_fault=1; sticky until reset; no enables.
- Wait counter: cleared on entry to FETCH/MEM; increments each FETCH/MEM cycle with I_mem_ready=0. Ready low while counter==MAX_WAIT-1 → FAULT. I_mem_ready=1 takes priority over timeout in the same cycle.
- Opcode, I_regwe and store/load class are sampled at DECODE/ALU exit edges; the decoder updates on the falling edge inside DECODE, so values are stable by the next rising edge. Class latched at end of DECODE and used in ALU/MEM.
- I_run deassertion never aborts an instruction; it only selects IDLE at completion.

## Timing
- Reset (async assert, any state): state IDLE, all 1-bit outputs 0, O_state=0, O_retired=0, wait counter 0. Release synchronous to next rising edge.
- Latency with zero wait states: non-writing op 4 cycles, ALU op with write-back 5, STORE 5, LOAD 6; each not-ready cycle adds 1.
- Back-to-back: with I_run=1 the next FETCH follows the completing cycle directly, with no bubble.
- Exactly one stage enable asserted per cycle outside IDLE/HALT/FAULT; O_mem_req is asserted only in FETCH/MEM.
- HALT reached one cycle after DECODE; FAULT is entered on the edge ending the MAX_WAIT-th consecutive not-ready cycle.

## Test plan
- Reset, I_run=1, ready always 1, opcode 5'b00000, I_regwe=1 → states 1,2,3,4,6,1; O_retired=1 after 5 cycles.
- LOAD (5'b10000), ready delayed 2 cycles in MEM → MEM held 3 cycles with O_mem_we=0, then WB; total 8 cycles.
- STORE (5'b10010) → MEM with O_mem_we=1, no WB; I_regwe=0 op (5'b01110) → ALU→FETCH in 4 cycles.
- MAX_WAIT=8, ready held 0 in FETCH → FAULT after 8 cycles, O_fault=1 sticky; ready=1 on 8th cycle instead → DECODE, no fault.
- HALT opcode 5'b11111 → HALT after DECODE, O_halted=1, O_retired unchanged, I_run toggles ignored.
- I_rst_n low mid-MEM → immediate IDLE, outputs 0; I_run dropped during REGREAD → instruction completes then IDLE; CNT_W=2, 5 instructions → O_retired=1.

Source files
------------

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer for the 16-bit RISC core.
// Steps each instruction through FETCH, DECODE, REGREAD, ALU, an optional MEM
// and WB, with one stage enable per cycle. It also detects HALT and memory
// timeout.
//
// Parameters
//   MAX_WAIT      consecutive not-ready cycles tolerated in FETCH/MEM (>=1)
//   CNT_W         width of the retired-instruction counter
// Ports
//   I_clk, I_rst_n    clock (rising edge), async active-low reset
//   I_run             keep issuing instructions
//   I_mem_ready       memory completes the current request this cycle
//   I_opcode, I_regwe decoder outputs (sampled at DECODE / ALU exit)
//   O_state           current state code
//   O_en_*, O_pc_inc  stage enables / PC strobe
//   O_mem_req/_we     memory request / store
//   O_halted, O_fault sticky terminal flags
//   O_retired         completed-instruction count (wraps)
module ctrl_seq #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_run,
  input  logic             I_mem_ready,
  input  logic [4:0]       I_opcode,
  input  logic             I_regwe,
  output logic [3:0]       O_state,
  output logic             O_en_fetch,
  output logic             O_en_decode,
  output logic             O_pc_inc,
  output logic             O_en_regread,
  output logic             O_en_alu,
  output logic             O_mem_req,
  output logic             O_mem_we,
  output logic             O_en_regwrite,
  output logic             O_halted,
  output logic             O_fault,
  output logic [CNT_W-1:0] O_retired
);

  // Wide enough to hold MAX_WAIT-1 even when MAX_WAIT is 1.
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_REGREAD = 4'd3,
    S_ALU     = 4'd4,
    S_MEM     = 4'd5,
    S_WB      = 4'd6,
    S_HALT    = 4'd7,
    S_FAULT   = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              load_q, load_d;
  logic              store_q, store_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  // A completing instruction returns to FETCH or parks in IDLE. It never
  // aborts mid-instruction when I_run drops.
  state_t            done_state;
  assign done_state = I_run ? S_FETCH : S_IDLE;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      load_q    <= load_d;
      store_q   <= store_d;
      retired_q <= retired_d;
    end
  end

  // Next state. The wait counter defaults to 0, so any entry into FETCH/MEM
  // starts from a cleared count. It only advances while stalled in place.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    load_d    = load_q;
    store_d   = store_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (I_run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (I_mem_ready)             state_d = S_DECODE;
        else if (wait_q == WAIT_LAST) state_d = S_FAULT;
        else                          wait_d  = wait_q + 1'b1;
      end
      S_DECODE: begin
        // The decoder settles on the falling edge inside DECODE, so the
        // opcode class is valid on this exit edge.
        load_d  = (I_opcode[4:1] == 4'b1000);
        store_d = (I_opcode[4:1] == 4'b1001);
        if (I_opcode == 5'b11111) state_d = S_HALT;
        else                      state_d = S_REGREAD;
      end
      S_REGREAD: state_d = S_ALU;
      S_ALU: begin
        if (load_q || store_q) state_d = S_MEM;
        else if (I_regwe)      state_d = S_WB;
        else begin
          state_d   = done_state;
          retired_d = retired_q + 1'b1;
        end
      end
      S_MEM: begin
        if (I_mem_ready) begin
          if (load_q) state_d = S_WB;
          else begin
            state_d   = done_state;
            retired_d = retired_q + 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        state_d   = done_state;
        retired_d = retired_q + 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs. These are decoded only from registered state.
  always_comb begin
    O_en_fetch    = 1'b0;
    O_en_decode   = 1'b0;
    O_pc_inc      = 1'b0;
    O_en_regread  = 1'b0;
    O_en_alu      = 1'b0;
    O_mem_req     = 1'b0;
    O_mem_we      = 1'b0;
    O_en_regwrite = 1'b0;
    O_halted      = 1'b0;
    O_fault       = 1'b0;
    case (state_q)
      S_FETCH: begin
        O_en_fetch = 1'b1;
        O_mem_req  = 1'b1;
      end
      S_DECODE: begin
        O_en_decode = 1'b1;
        O_pc_inc    = 1'b1;
      end
      S_REGREAD: O_en_regread = 1'b1;
      S_ALU:     O_en_alu     = 1'b1;
      S_MEM: begin
        O_mem_req = 1'b1;
        O_mem_we  = store_q;
      end
      S_WB:    O_en_regwrite = 1'b1;
      S_HALT:  O_halted      = 1'b1;
      S_FAULT: O_fault       = 1'b1;
      default: ;
    endcase
  end

  assign O_state   = state_q;
  assign O_retired = retired_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed, table-driven bench for ctrl_seq. A second instance with CNT_W=2
// shares all inputs, so that the counter wrap can be observed.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, rdy, regwe;
  logic [4:0] op;

  logic [3:0]  st, st2;
  logic [15:0] ret;
  logic [1:0]  ret2;
  logic        f, d, p, rr, a, mq, mw, rw, h, flt;
  logic        f2, d2, p2, rr2, a2, mq2, mw2, rw2, h2, flt2;
  logic [9:0]  outs;

  assign outs = {f, d, p, rr, a, mq, mw, rw, h, flt};

  always #5 clk = ~clk;

  ctrl_seq #(.MAX_WAIT(8), .CNT_W(16)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_run(run), .I_mem_ready(rdy),
    .I_opcode(op), .I_regwe(regwe), .O_state(st),
    .O_en_fetch(f), .O_en_decode(d), .O_pc_inc(p), .O_en_regread(rr),
    .O_en_alu(a), .O_mem_req(mq), .O_mem_we(mw), .O_en_regwrite(rw),
    .O_halted(h), .O_fault(flt), .O_retired(ret));

  ctrl_seq #(.MAX_WAIT(8), .CNT_W(2)) dut2 (
    .I_clk(clk), .I_rst_n(rst_n), .I_run(run), .I_mem_ready(rdy),
    .I_opcode(op), .I_regwe(regwe), .O_state(st2),
    .O_en_fetch(f2), .O_en_decode(d2), .O_pc_inc(p2), .O_en_regread(rr2),
    .O_en_alu(a2), .O_mem_req(mq2), .O_mem_we(mw2), .O_en_regwrite(rw2),
    .O_halted(h2), .O_fault(flt2), .O_retired(ret2));

  // Expected output bundles: {fetch,decode,pc_inc,regread,alu,mem_req,mem_we,regwrite,halted,fault}
  localparam logic [9:0] IDL = 10'b0_0_0_0_0_0_0_0_0_0;
  localparam logic [9:0] FET = 10'b1_0_0_0_0_1_0_0_0_0;
  localparam logic [9:0] DEC = 10'b0_1_1_0_0_0_0_0_0_0;
  localparam logic [9:0] RRD = 10'b0_0_0_1_0_0_0_0_0_0;
  localparam logic [9:0] ALU = 10'b0_0_0_0_1_0_0_0_0_0;
  localparam logic [9:0] MLD = 10'b0_0_0_0_0_1_0_0_0_0;
  localparam logic [9:0] MST = 10'b0_0_0_0_0_1_1_0_0_0;
  localparam logic [9:0] WBK = 10'b0_0_0_0_0_0_0_1_0_0;
  localparam logic [9:0] HLT = 10'b0_0_0_0_0_0_0_0_1_0;
  localparam logic [9:0] FLT = 10'b0_0_0_0_0_0_0_0_0_1;

  typedef struct {
    logic       run;
    logic       rdy;
    logic [4:0] op;
    logic       we;
    logic [3:0] st;
    logic [9:0] outs;
    int         ret;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(logic r, logic y, logic [4:0] o, logic w,
                              logic [3:0] s, logic [9:0] ob, int n);
    vec_t v;
    v.run = r; v.rdy = y; v.op = o; v.we = w; v.st = s; v.outs = ob; v.ret = n;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge. Then check the state that
  // this cycle is in. The outputs are Moore, so they do not depend on the
  // new inputs.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    run = v.run; rdy = v.rdy; op = v.op; regwe = v.we;
    #1;
    chk("state", idx, 32'(st), 32'(v.st));
    chk("outs", idx, 32'(outs), 32'(v.outs));
    chk("retired", idx, 32'(ret), 32'(v.ret));
    chk("state_w2", idx, 32'(st2), 32'(v.st));
    chk("retired_w2", idx, 32'(ret2), 32'(v.ret % 4));
  endtask

  // Assert reset away from any edge and check its effect at once. Then
  // release it on a falling edge.
  task automatic do_reset(input int idx);
    #2 rst_n = 1'b0; run = 1'b0; rdy = 1'b0; op = 5'd0; regwe = 1'b0;
    #1;
    chk("rst_state", idx, 32'(st), 32'd0);
    chk("rst_outs", idx, 32'(outs), 32'(IDL));
    chk("rst_retired", idx, 32'(ret), 32'd0);
    chk("rst_retired_w2", idx, 32'(ret2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; run = 1'b0; rdy = 1'b0; op = 5'd0; regwe = 1'b0;
    @(negedge clk);
    do_reset(0);

    // ALU op with write-back: IDLE,FETCH,DECODE,REGREAD,ALU,WB.
    vecs.push_back(mk(1,1,5'b00000,1, 0,IDL,0));
    vecs.push_back(mk(1,1,5'b00000,1, 1,FET,0));
    vecs.push_back(mk(1,1,5'b00000,1, 2,DEC,0));
    vecs.push_back(mk(1,1,5'b00000,1, 3,RRD,0));
    vecs.push_back(mk(1,1,5'b00000,1, 4,ALU,0));
    vecs.push_back(mk(1,1,5'b00000,1, 6,WBK,0));
    // LOAD with ready low for 2 MEM cycles: 8 cycles in total.
    vecs.push_back(mk(1,1,5'b10000,0, 1,FET,1));
    vecs.push_back(mk(1,1,5'b10000,0, 2,DEC,1));
    vecs.push_back(mk(1,1,5'b10000,0, 3,RRD,1));
    vecs.push_back(mk(1,1,5'b10000,0, 4,ALU,1));
    vecs.push_back(mk(1,0,5'b10000,0, 5,MLD,1));
    vecs.push_back(mk(1,0,5'b10000,0, 5,MLD,1));
    vecs.push_back(mk(1,1,5'b10000,0, 5,MLD,1));
    vecs.push_back(mk(1,1,5'b10000,0, 6,WBK,1));
    // STORE with regwe high: it still skips WB.
    vecs.push_back(mk(1,1,5'b10010,1, 1,FET,2));
    vecs.push_back(mk(1,1,5'b10010,1, 2,DEC,2));
    vecs.push_back(mk(1,1,5'b10010,1, 3,RRD,2));
    vecs.push_back(mk(1,1,5'b10010,1, 4,ALU,2));
    vecs.push_back(mk(1,1,5'b10010,1, 5,MST,2));
    // Non-writing op: completes out of ALU.
    vecs.push_back(mk(1,1,5'b01110,0, 1,FET,3));
    vecs.push_back(mk(1,1,5'b01110,0, 2,DEC,3));
    vecs.push_back(mk(1,1,5'b01110,0, 3,RRD,3));
    vecs.push_back(mk(1,1,5'b01110,0, 4,ALU,3));
    // FETCH with ready only on the 8th cycle: no fault. Then run drops in REGREAD.
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1,0,5'b00001,1, 1,FET,4));
    vecs.push_back(mk(1,1,5'b00001,1, 1,FET,4));
    vecs.push_back(mk(1,1,5'b00001,1, 2,DEC,4));
    vecs.push_back(mk(0,1,5'b00001,1, 3,RRD,4));
    vecs.push_back(mk(0,1,5'b00001,1, 4,ALU,4));
    vecs.push_back(mk(0,1,5'b00001,1, 6,WBK,4));
    vecs.push_back(mk(0,1,5'b00001,1, 0,IDL,5));   // narrow counter wrapped to 1
    vecs.push_back(mk(1,1,5'b00001,1, 0,IDL,5));
    // FETCH timeout: 8 not-ready cycles lead to FAULT, and FAULT is sticky.
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1,0,5'b00000,0, 1,FET,5));
    vecs.push_back(mk(1,1,5'b00000,0, 8,FLT,5));
    vecs.push_back(mk(0,0,5'b00000,0, 8,FLT,5));
    vecs.push_back(mk(1,1,5'b00000,0, 8,FLT,5));

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset out of FAULT, then run HALT: sticky, run ignored, and not retired.
    do_reset(100);
    apply(mk(1,1,5'b11111,0, 0,IDL,0), 101);
    apply(mk(1,1,5'b11111,0, 1,FET,0), 102);
    apply(mk(1,1,5'b11111,0, 2,DEC,0), 103);
    apply(mk(0,1,5'b00000,0, 7,HLT,0), 104);
    apply(mk(1,1,5'b00000,0, 7,HLT,0), 105);
    apply(mk(0,0,5'b00000,1, 7,HLT,0), 106);
    apply(mk(1,1,5'b00000,1, 7,HLT,0), 107);

    // Reset out of HALT. Retire one op, then reset in the middle of a MEM cycle.
    do_reset(200);
    apply(mk(1,1,5'b00000,0, 0,IDL,0), 201);
    apply(mk(1,1,5'b00000,0, 1,FET,0), 202);
    apply(mk(1,1,5'b00000,0, 2,DEC,0), 203);
    apply(mk(1,1,5'b00000,0, 3,RRD,0), 204);
    apply(mk(1,1,5'b00000,0, 4,ALU,0), 205);
    apply(mk(1,1,5'b10000,0, 1,FET,1), 206);
    apply(mk(1,1,5'b10000,0, 2,DEC,1), 207);
    apply(mk(1,1,5'b10000,0, 3,RRD,1), 208);
    apply(mk(1,1,5'b10000,0, 4,ALU,1), 209);
    apply(mk(1,0,5'b10000,0, 5,MLD,1), 210);
    do_reset(211);

    // STORE timing out in MEM after 8 not-ready cycles.
    apply(mk(1,1,5'b10011,0, 0,IDL,0), 301);
    apply(mk(1,1,5'b10011,0, 1,FET,0), 302);
    apply(mk(1,1,5'b10011,0, 2,DEC,0), 303);
    apply(mk(1,1,5'b10011,0, 3,RRD,0), 304);
    apply(mk(1,1,5'b10011,0, 4,ALU,0), 305);
    for (int i = 0; i < 8; i++) apply(mk(1,0,5'b10011,0, 5,MST,0), 306 + i);
    apply(mk(1,1,5'b10011,0, 8,FLT,0), 314);
    apply(mk(0,1,5'b10011,0, 8,FLT,0), 315);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
